seq_detector_prog: RTL
======================

// Module: seq_detector_prog
// PURPOSE
//  Programmable serial bit-pattern detector; next generation of our fixed 4-state Mealy detectors.
//  Matches a runtime-loaded pattern of 1..MAX_LEN bits on a qualified serial stream.
//  Supports overlapping and non-overlapping detection, and counts matches.
//  Sits between a serial deframer and the framing/alignment control logic.
// PARAMETERS
//  MAX_LEN  8          maximum pattern length in bits (>=2)
//  CNT_W    16         width of match counter
//  PAT_RST  8'b1010    pattern loaded at reset (LSB-aligned)
//  LEN_RST  4          pattern length loaded at reset (1..MAX_LEN)
//  OVL_RST  1'b1       overlap mode loaded at reset
// PORTS
//  clk          in   1                   clock, all state on rising edge
//  reset        in   1                   synchronous, active-high
//  din_valid    in   1                   din qualifier; din ignored when 0
//  din          in   1                   serial data bit
//  cfg_load     in   1                   load cfg_* at this edge
//  cfg_pattern  in   MAX_LEN             pattern, LSB-aligned; bit[len-1] first received, bit[0] last
//  cfg_len      in   $clog2(MAX_LEN+1)   pattern length
//  cfg_overlap  in   1                   1 = overlapping, 0 = non-overlapping
//  count_clr    in   1                   clear match_count
//  match        out  1                   Mealy (combinational) match on current din
//  match_q      out  1                   match registered (1-cycle delayed copy)
//  match_count  out  CNT_W               saturating number of matches
//  cfg_err      out  1                   registered 1-cycle pulse: rejected cfg_load
// BEHAVIOUR
//  Reset: pattern=PAT_RST, len=LEN_RST, overlap=OVL_RST, hist=0, fill=0, match_q=0,
//   match_count=0, cfg_err=0; match forced 0 while reset=1.
//  State: hist (MAX_LEN-1 bits, shift-in at LSB) + fill (bits seen since last clear, saturates at MAX_LEN-1).
//  match = din_valid & ~reset & ~cfg_load & (fill >= len-1) & ({hist[len-2:0],din} == pattern[len-1:0]).
//   len==1: match = din_valid & (din == pattern[0]); hist unused.
//  Latency: match same cycle as last pattern bit (Mealy); match_q and match_count update at that edge.
//  Edge with din_valid=1: hist <= {hist,din}; fill++ (saturating).
//   Non-overlap and match: hist <= 0, fill <= 0 instead (matched bits not reused).
//   Overlap and match: normal shift, matched bits reusable.
//  din_valid=0: hist/fill hold; match=0.
//  cfg_load: legal if 1<=cfg_len<=MAX_LEN -> latch pattern/len/overlap, clear hist/fill;
//   illegal (0 or >MAX_LEN) -> config unchanged, hist/fill unchanged, cfg_err=1 next cycle.
//   din in a cfg_load cycle is discarded (match=0, no shift) in both cases.
//   Pattern bits above len-1 are don't-care.
//  match_count: +1 per match, saturates at all-ones (no wrap).
//   count_clr with simultaneous match -> count_clr wins, count = 0.
//  Reset mid-stream: partial history discarded, config reverts to *_RST values.
//  Default config (1010, overlap) reproduces legacy detector: "1010" -> match, next "10" -> match again.
// STRUCTURE
//  Package seq_det_pkg: LEN_W function/constant ($clog2(MAX_LEN+1)), defaults PAT_RST/LEN_RST/OVL_RST,
//   helper function for length mask (bits [len-1:0]).
//  One sub-module: seq_det_history (hist shift register + saturating fill counter, clear/shift/hold).
//  Top holds config registers, masked comparator, match_q, counter, cfg_err.
// TESTING
//  Default cfg, valid stream 1,0,1,0,1,0 -> match on bits 4 and 6; match_count=2; match_q 1 cycle later.
//  Load 1010 non-overlap, stream 1,0,1,0,1,0 -> match on bit 4 only; count=1.
//  Load len=3 pattern 110, stream 1,1,valid=0 gap x3,0 -> match on the 0 (gaps hold state).
//  cfg_load with cfg_len=0 and with len=MAX_LEN+1 -> cfg_err pulse, later stream matches old pattern.
//  CNT_W=2, 5 matches -> count sticks at 3; count_clr on a match cycle -> count=0.
//  Reset asserted after 3 bits of 1010 -> no match on 4th bit; config back to PAT_RST/LEN_RST.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable sequence detector.
//   len_w()    : width needed to hold a pattern length of 0..max_len
//   DEF_*      : power-on pattern / length / overlap mode
//   len_mask() : mask with bits [len-1:0] set (supports patterns up to 32 bits)
package seq_det_pkg;

    localparam logic [7:0] DEF_PAT = 8'b0000_1010;
    localparam int unsigned DEF_LEN = 4;
    localparam logic DEF_OVL = 1'b1;

    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic logic [31:0] len_mask(input int unsigned len);
        if (len >= 32) begin
            return '1;
        end
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/seq_detector_prog_if.sv
// Bus bundle for seq_detector_prog.
//   din_valid/din          : qualified serial input stream
//   cfg_load/cfg_pattern/cfg_len/cfg_overlap : runtime pattern configuration
//   count_clr              : clear the match counter
//   match/match_q/match_count/cfg_err        : detector results
// slave modport is the detector side; master modport is the driver side.
interface seq_detector_prog_if
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned LEN_W = len_w(MAX_LEN);

    logic               din_valid;
    logic               din;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               count_clr;
    logic               match;
    logic               match_q;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    modport slave (
        input  din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clr,
        output match, match_q, match_count, cfg_err
    );

    modport master (
        output din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clr,
        input  match, match_q, match_count, cfg_err
    );

endinterface

// File: rtl/seq_det_history.sv
// History shift register plus saturating fill counter.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : clear history and fill (has priority over shift)
//   shift_i    : shift din_i in at the LSB and bump fill
//   din_i      : serial bit
//   hist_o     : last MAX_LEN-1 bits, newest at bit 0
//   fill_o     : bits seen since last clear, saturating at MAX_LEN-1
module seq_det_history #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               shift_i,
    input  logic               din_i,
    output logic [MAX_LEN-2:0] hist_o,
    output logic [LEN_W-1:0]   fill_o
);
    localparam int unsigned HW = MAX_LEN - 1;
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

    logic [HW-1:0]    hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            // Oldest bit drops off the top; works for HW == 1 too.
            hist_d = HW'({hist_q, din_i});
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist_o = hist_q;
    assign fill_o = fill_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector (1..MAX_LEN bits, runtime loaded).
//   clk, reset : clock, synchronous active-high reset
//   bus        : seq_detector_prog_if.slave (stream in, config in, results out)
// match is Mealy on the current din; match_q, match_count and cfg_err are
// registered. Overlapping or non-overlapping detection is selectable.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int unsigned        MAX_LEN = 8,
    parameter int unsigned        CNT_W   = 16,
    parameter logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(DEF_PAT),
    parameter int unsigned        LEN_RST = DEF_LEN,
    parameter logic               OVL_RST = DEF_OVL
) (
    input  logic               clk,
    input  logic               reset,
    seq_detector_prog_if.slave bus
);
    localparam int unsigned LEN_W = len_w(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;
    logic               hist_clr, hist_shift;
    logic               cfg_legal, hit, enough, match;
    logic [MAX_LEN-1:0] window, mask;

    seq_det_history #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (hist_clr),
        .shift_i (hist_shift),
        .din_i   (bus.din),
        .hist_o  (hist),
        .fill_o  (fill)
    );

    always_comb begin
        cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));

        // Window holds the last len bits with the live din at bit 0, so it lines
        // up with the LSB-aligned pattern; bits above len-1 are masked out.
        window = {hist, bus.din};
        mask   = MAX_LEN'(len_mask(32'(len_q)));
        hit    = ((window ^ pat_q) & mask) == '0;
        enough = fill >= (len_q - LEN_W'(1));
        match  = bus.din_valid & ~reset & ~bus.cfg_load & enough & hit;

        // A config-cycle din is dropped; a legal load or a non-overlap match
        // restarts the history.
        hist_clr   = (bus.cfg_load & cfg_legal) | (match & ~ovl_q);
        hist_shift = bus.din_valid & ~bus.cfg_load;

        pat_d = pat_q;
        len_d = len_q;
        ovl_d = ovl_q;
        if (bus.cfg_load && cfg_legal) begin
            pat_d = bus.cfg_pattern;
            len_d = bus.cfg_len;
            ovl_d = bus.cfg_overlap;
        end

        cnt_d = cnt_q;
        if (bus.count_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        match_d = match;
        err_d   = bus.cfg_load & ~cfg_legal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= PAT_RST;
            len_q   <= LEN_W'(LEN_RST);
            ovl_q   <= OVL_RST;
            match_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.match       = match;
    assign bus.match_q     = match_q;
    assign bus.match_count = cnt_q;
    assign bus.cfg_err     = err_q;

endmodule
